// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the single line-wide memory port between the L1
// I-cache and D-cache. One line transaction at a time, round-robin on
// contention, response routed only to the cache that owns the transfer.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no owner; pick the next requester (also the inter-grant bubble)
// SERVE_I | memory port owned by the I-cache until pmem_resp
// SERVE_D | memory port owned by the D-cache until pmem_resp
module cache_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [LINE_WIDTH-1:0] pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state_q;
  logic   last_grant_q;  // 0 = I-cache, 1 = D-cache

  logic i_req;
  logic d_req;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

  // Grant sequencing: decide in IDLE, hold ownership until memory completes.
  // Returning to IDLE after every transfer gives the requester one cycle to
  // drop its request before anything is sampled again.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req && d_req) begin
            state_q <= last_grant_q ? SERVE_I : SERVE_D;
          end else if (i_req) begin
            state_q <= SERVE_I;
          end else if (d_req) begin
            state_q <= SERVE_D;
          end
        end
        SERVE_I: begin
          if (pmem_resp) begin
            last_grant_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        SERVE_D: begin
          if (pmem_resp) begin
            last_grant_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Port routing: memory side follows the owning cache; a pmem_resp seen
  // while idle has no owner and is dropped.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    case (state_q)
      SERVE_I: begin
        pmem_read    = i_read;
        pmem_write   = i_write;
        pmem_address = i_address;
        pmem_wdata   = i_wdata;
        i_resp       = pmem_resp;
      end
      SERVE_D: begin
        pmem_read    = d_read;
        pmem_write   = d_write;
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        d_resp       = pmem_resp;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; each cache qualifies it with its own resp.
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single lower-level memory port (L2 / physical memory, one 128-bit line per transfer) between the split L1 I-cache and D-cache of the pipelined LC-3b.
- Sits between both L1 miss/writeback interfaces and the memory side.
- Sequences one line transaction at a time, grants round-robin under contention and routes the response back to the granted requester only.

Parameters:
- ADDR_WIDTH, 16, line address width (lc3b_word).
- LINE_WIDTH, 128, line data width (lc3b_line).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_read  in  1  I-cache line read request, level, held until i_resp
- i_write  in  1  I-cache line write request (tied 0 by I-cache; supported)
- i_address  in  ADDR_WIDTH  I-cache line address
- i_wdata  in  LINE_WIDTH  I-cache write line
- i_resp  out  1  one-cycle completion pulse to I-cache
- i_rdata  out  LINE_WIDTH  read line to I-cache
- d_read, d_write, d_address, d_wdata  in  same as I-side, for the D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- d_rdata  out  LINE_WIDTH  read line to D-cache
- pmem_read  out  1  memory read strobe, level
- pmem_write  out  1  memory write strobe, level
- pmem_address  out  ADDR_WIDTH  memory line address
- pmem_wdata  out  LINE_WIDTH  memory write line
- pmem_resp  in  1  one-cycle completion pulse from memory
- pmem_rdata  in  LINE_WIDTH  memory read line

Behaviour:
- Request protocol, both sides: a requester asserts read or write with stable address/wdata until it samples resp=1, then deasserts on the next cycle. read and write asserted together is illegal; bench asserts on it, RTL need not handle it.
- States: IDLE, SERVE_I, SERVE_D. Registers: state, last_grant (0=I, 1=D).
- Reset: state=IDLE, last_grant=I, so the first contention goes to D. All outputs 0 in IDLE.
- IDLE: pmem_read=pmem_write=0 and both resp=0.
  - Only I requesting → SERVE_I.
  - Only D requesting → SERVE_D.
  - Both requesting → serve the side that is not last_grant.
  - Grant decision registered; no memory strobe in the decision cycle.
- SERVE_x:
  - pmem_read/write/address/wdata combinationally follow requester x's inputs.
  - pmem_resp is routed combinationally to x_resp, same cycle; the other resp stays 0.
  - On pmem_resp=1: last_grant<=x, state<=IDLE.
  - The non-granted side waits; its request stays held and is never dropped.
- rdata: pmem_rdata is driven to both i_rdata and d_rdata. Valid only when the matching resp=1.
- Latency:
  - Request seen at edge t → strobe high from cycle t+1.
  - pmem_resp in cycle t+k → x_resp in the same cycle t+k.
  - Mandatory single IDLE bubble between transactions, so the requester's deassertion is never mistaken for a new request.
- Back-to-back, one requester re-requesting immediately with no contention: served again after the IDLE bubble.
- Fairness: under continuous contention grants alternate D,I,D,I. Max wait for either side is one foreign transaction.
- If the granted requester withdraws without resp (illegal): strobe drops and the arbiter stays in SERVE_x until pmem_resp.
- pmem_resp while IDLE: ignored, no resp to either side.
- rst mid-transaction: state=IDLE on the next edge and strobes drop. Memory side must tolerate an abandoned request. last_grant resets to I.

Test Plan:
- Single I read: i_read=1, i_address=16'h0040; memory returns pmem_rdata=128'hA5..A5 with pmem_resp 3 cycles later → pmem_read high from cycle 1; i_resp=1 with i_rdata=A5..A5 for exactly 1 cycle; d_resp stays 0.
- Simultaneous first requests after reset: i_read@16'h0100, d_write@16'h2000 with wdata=128'h1234… → D served first (pmem_write=1, pmem_address=16'h2000). Then IDLE for one cycle, then I served (pmem_read, address 16'h0100).
- Continuous contention, 6 transactions → grant order D,I,D,I,D,I, with exactly one IDLE cycle between consecutive grants.
- D write in progress, I request arrives mid-service → pmem_address stays 16'h2000 until pmem_resp; I served after the bubble; i_resp never pulses early.
- rst asserted during SERVE_I before pmem_resp → next cycle pmem_read=0, state IDLE, no i_resp. After rst deasserts with both requesting, D is granted first.
- Stray pmem_resp pulse in IDLE → i_resp=d_resp=0, state unchanged.
